// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
// Shared types and constants for the unified memory-port arbiter.
//   arb_state_e : FSM states IDLE / BUSY / RESP
//   owner_e     : which requester owns the transaction (OWN_I = fetch, OWN_D = load/store)
//   ARB_RR      : round-robin arbitration mode
//   ARB_DPRIO   : fixed data-side priority mode
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_DPRIO = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
// Bundles the fetch requester, the load/store requester and the memory-side
// port of the arbiter.
//   i_*  : fetch request (i_req/i_addr in, i_ready/i_rdata/i_err out of arbiter)
//   d_*  : data request  (d_req/d_we/d_be/d_addr/d_wdata in, d_ready/d_rdata/d_err out)
//   m_*  : memory port   (m_en/m_we/m_be/m_addr/m_wdata out, m_rdata/m_ack in)
// Modports: slave = arbiter view, master = requester/memory environment view.
//
// Handshake: a requester raises *_req with stable attributes and holds them
// until its *_ready pulses for exactly one cycle; it drops *_req in the cycle
// after ready. On the memory side m_en is high for the whole transaction and
// m_ack pulses once with m_rdata valid in that same cycle.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_req;
    logic [AW-1:0]   i_addr;
    logic            i_ready;
    logic [DW-1:0]   i_rdata;
    logic            i_err;

    logic            d_req;
    logic            d_we;
    logic [DW/8-1:0] d_be;
    logic [AW-1:0]   d_addr;
    logic [DW-1:0]   d_wdata;
    logic            d_ready;
    logic [DW-1:0]   d_rdata;
    logic            d_err;

    logic            m_en;
    logic            m_we;
    logic [DW/8-1:0] m_be;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [DW-1:0]   m_rdata;
    logic            m_ack;

    modport slave (
        input  i_req, i_addr,
        output i_ready, i_rdata, i_err,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_ready, d_rdata, d_err,
        output m_en, m_we, m_be, m_addr, m_wdata,
        input  m_rdata, m_ack
    );

    modport master (
        output i_req, i_addr,
        input  i_ready, i_rdata, i_err,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_ready, d_rdata, d_err,
        input  m_en, m_we, m_be, m_addr, m_wdata,
        output m_rdata, m_ack
    );

endinterface

// File: rtl/arb2_rr.sv
// arb2_rr
// Combinational two-way grant between a fetch and a data requester.
//   req_i, req_d : request lines
//   last_grant   : owner of the most recently completed transaction
//   mode         : ARB_RR (alternate on contention) or ARB_DPRIO (data wins)
//   grant_valid  : at least one request present
//   grant_owner  : selected requester (meaningful only with grant_valid)
module arb2_rr
    import mem_arb_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_e last_grant,
    input  logic   mode,
    output logic   grant_valid,
    output owner_e grant_owner
);

    always_comb begin
        grant_valid = req_i | req_d;
        grant_owner = OWN_I;
        if (req_i && req_d) begin
            if (mode == ARB_DPRIO) begin
                grant_owner = OWN_D;
            end else begin
                // On contention hand the port to whoever was not served last.
                grant_owner = (last_grant == OWN_D) ? OWN_I : OWN_D;
            end
        end else if (req_d) begin
            grant_owner = OWN_D;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one memory port between instruction fetch and load/store. One
// transaction is in flight at a time: IDLE grants, BUSY holds the memory
// request until m_ack (or the watchdog expires), RESP returns a one-cycle
// ready/err pulse to the owner and then goes back to IDLE.
//   CLK         : clock, rising edge
//   RES         : asynchronous reset, active low
//   bus         : requester and memory signals (mem_port_arbiter_if.slave)
//   o_dbg_state : current FSM state (IDLE=0, BUSY=1, RESP=2)
// Parameters: AW/DW widths, ARB_MODE (0 round-robin, 1 data priority),
// TIMEOUT (BUSY cycles before giving up on m_ack, 0 = never).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic              CLK,
    input  logic              RES,
    mem_port_arbiter_if.slave bus,
    output logic [1:0]        o_dbg_state
);

    localparam int BW = DW / 8;
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_BUSY = BUSY;
    localparam logic [1:0] ST_RESP = RESP;

    logic [1:0]    r_state;
    owner_e        r_owner;
    owner_e        r_last_grant;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [BW-1:0] r_be;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic          w_mode;
    logic          w_grant_valid;
    owner_e        w_grant_owner;
    logic          w_timeout;
    logic          w_busy;
    logic          w_resp;
    logic          w_i_ready;
    logic          w_d_ready;

    assign w_mode = (ARB_MODE == 1) ? ARB_DPRIO : ARB_RR;

    arb2_rr u_arb (
        .req_i       (bus.i_req),
        .req_d       (bus.d_req),
        .last_grant  (r_last_grant),
        .mode        (w_mode),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    // Counter holds (BUSY cycles elapsed - 1); expiry on the TIMEOUT-th cycle.
    assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RES) begin
        if (!RES) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWN_I;
            r_last_grant <= OWN_D;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_be         <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_valid) begin
                        r_owner <= w_grant_owner;
                        r_cnt   <= '0;
                        r_state <= ST_BUSY;
                        if (w_grant_owner == OWN_D) begin
                            r_addr  <= bus.d_addr;
                            r_we    <= bus.d_we;
                            r_be    <= bus.d_be;
                            r_wdata <= bus.d_wdata;
                        end else begin
                            // Fetches are always full-word reads.
                            r_addr  <= bus.i_addr;
                            r_we    <= 1'b0;
                            r_be    <= '1;
                            r_wdata <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    // An ack in the expiry cycle still counts as a normal completion.
                    if (bus.m_ack) begin
                        r_rdata      <= r_we ? '0 : bus.m_rdata;
                        r_err        <= 1'b0;
                        r_last_grant <= r_owner;
                        r_state      <= ST_RESP;
                    end else if (w_timeout) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_busy    = (r_state == ST_BUSY);
    assign w_resp    = (r_state == ST_RESP);
    assign w_i_ready = w_resp && (r_owner == OWN_I);
    assign w_d_ready = w_resp && (r_owner == OWN_D);

    // Memory side is gated by BUSY so it drops asynchronously with reset.
    assign bus.m_en    = w_busy;
    assign bus.m_we    = w_busy & r_we;
    assign bus.m_be    = w_busy ? r_be    : '0;
    assign bus.m_addr  = w_busy ? r_addr  : '0;
    assign bus.m_wdata = w_busy ? r_wdata : '0;

    // Only the owner sees a response; the other side stays at zero.
    assign bus.i_ready = w_i_ready;
    assign bus.i_rdata = w_i_ready ? r_rdata : '0;
    assign bus.i_err   = w_i_ready & r_err;
    assign bus.d_ready = w_d_ready;
    assign bus.d_rdata = w_d_ready ? r_rdata : '0;
    assign bus.d_err   = w_d_ready & r_err;

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int W  = 33;                         // {owner, rdata}
  localparam logic [31:0] MEM_OFS = 32'hDEAD_BDEF; // read data = addr + MEM_OFS

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg_rr;
  logic [1:0] dbg_dp;

  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];

  int rr_delay = 1;
  int dp_delay = 1;
  int rr_cnt = 0;
  int dp_cnt = 0;
  logic rr_spur = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  // ---------------- DUTs ----------------
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_rr();
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus_dp();

  mem_port_arbiter #(.AW(AW), .DW(DW), .ARB_MODE(0), .TIMEOUT(8)) dut_rr (
    .CLK(clk), .RES(rst_n), .bus(bus_rr), .o_dbg_state(dbg_rr));
  mem_port_arbiter #(.AW(AW), .DW(DW), .ARB_MODE(1), .TIMEOUT(8)) dut_dp (
    .CLK(clk), .RES(rst_n), .bus(bus_dp), .o_dbg_state(dbg_dp));

  // ---------------- memory responders ----------------
  // Ack after <delay> further cycles of m_en; garbage data when not acking.
  always @(negedge clk) begin
    if (bus_rr.m_en && rr_cnt == rr_delay) begin
      bus_rr.m_ack = 1'b1;
      bus_rr.m_rdata = bus_rr.m_addr + MEM_OFS;
    end else begin
      bus_rr.m_ack = !bus_rr.m_en && rr_spur;
      bus_rr.m_rdata = 32'h0BAD_F00D;
    end
    rr_cnt = bus_rr.m_en ? rr_cnt + 1 : 0;
  end

  always @(negedge clk) begin
    if (bus_dp.m_en && dp_cnt == dp_delay) begin
      bus_dp.m_ack = 1'b1;
      bus_dp.m_rdata = bus_dp.m_addr + MEM_OFS;
    end else begin
      bus_dp.m_ack = 1'b0;
      bus_dp.m_rdata = 32'h0BAD_F00D;
    end
    dp_cnt = bus_dp.m_en ? dp_cnt + 1 : 0;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Waits (bounded) for a ready pulse on one DUT; returns cycles waited, owner and data.
  task automatic wait_ready(input bit dp, output int cyc, output logic own_d,
                            output logic [DW-1:0] rdata, output logic err);
    logic ir, dr;
    cyc = -1; own_d = 1'b0; rdata = '0; err = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      ir = dp ? bus_dp.i_ready : bus_rr.i_ready;
      dr = dp ? bus_dp.d_ready : bus_rr.d_ready;
      if (ir || dr) begin
        check("single_ready", {63'd0, ir & dr}, 64'd0);
        cyc = n;
        own_d = dr;
        if (dp) begin
          rdata = dr ? bus_dp.d_rdata : bus_dp.i_rdata;
          err   = dr ? bus_dp.d_err : bus_dp.i_err;
        end else begin
          rdata = dr ? bus_rr.d_rdata : bus_rr.i_rdata;
          err   = dr ? bus_rr.d_err : bus_rr.i_err;
        end
        return;
      end
    end
    check("ready_timeout", 64'd1, 64'd0);
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    bus_rr.i_req = 0; bus_rr.i_addr = '0;
    bus_rr.d_req = 0; bus_rr.d_we = 0; bus_rr.d_be = '0; bus_rr.d_addr = '0; bus_rr.d_wdata = '0;
    bus_dp.i_req = 0; bus_dp.i_addr = '0;
    bus_dp.d_req = 0; bus_dp.d_we = 0; bus_dp.d_be = '0; bus_dp.d_addr = '0; bus_dp.d_wdata = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    int busy;
    logic own_d;
    logic [DW-1:0] rd;
    logic er;
    logic [W-1:0] e;

    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("rst_state", {62'd0, dbg_rr}, 64'd0);
    check("rst_m_en", {63'd0, bus_rr.m_en}, 64'd0);
    check("rst_ready", {62'd0, bus_rr.i_ready, bus_rr.d_ready}, 64'd0);
    check("rst_m_addr", {32'd0, bus_rr.m_addr}, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // Single fetch: memory acks one cycle after m_en.
    @(posedge clk); #1;
    bus_rr.i_req = 1; bus_rr.i_addr = 32'h100;
    @(posedge clk); #1;
    check("f_m_en", {63'd0, bus_rr.m_en}, 64'd1);
    check("f_m_addr", {32'd0, bus_rr.m_addr}, 64'h100);
    check("f_m_we", {63'd0, bus_rr.m_we}, 64'd0);
    check("f_m_be", {60'd0, bus_rr.m_be}, 64'hF);
    wait_ready(0, cyc, own_d, rd, er);
    check("f_latency", 64'(cyc + 1), 64'd3);
    check("f_owner", {63'd0, own_d}, 64'd0);
    check("f_rdata", {32'd0, rd}, 64'hDEADBEEF);
    check("f_err", {63'd0, er}, 64'd0);
    bus_rr.i_req = 0;
    @(posedge clk); #1;
    check("f_pulse", {63'd0, bus_rr.i_ready}, 64'd0);

    // Round-robin with both requesters held from reset: I, D, I, D.
    rst_n = 1'b0;
    bus_rr.i_req = 1; bus_rr.i_addr = 32'h40;
    bus_rr.d_req = 1; bus_rr.d_we = 0; bus_rr.d_be = 4'hF; bus_rr.d_addr = 32'h80;
    exp_q.push_back({1'b0, 32'h40 + MEM_OFS});
    exp_q.push_back({1'b1, 32'h80 + MEM_OFS});
    exp_q.push_back({1'b0, 32'h40 + MEM_OFS});
    exp_q.push_back({1'b1, 32'h80 + MEM_OFS});
    apply_reset();
    for (int t = 0; t < 4; t++) begin
      wait_ready(0, cyc, own_d, rd, er);
      e = exp_q.pop_front();
      check("rr_txn", {31'd0, own_d, rd}, {31'd0, e});
      @(posedge clk); #1;
      check("rr_pulse", {62'd0, bus_rr.i_ready, bus_rr.d_ready}, 64'd0);
    end
    idle_inputs();

    // Fixed D priority: D, D, then I once d_req drops.
    rst_n = 1'b0;
    bus_dp.i_req = 1; bus_dp.i_addr = 32'h44;
    bus_dp.d_req = 1; bus_dp.d_we = 0; bus_dp.d_be = 4'hF; bus_dp.d_addr = 32'h88;
    exp_q.push_back({1'b1, 32'h88 + MEM_OFS});
    exp_q.push_back({1'b1, 32'h88 + MEM_OFS});
    exp_q.push_back({1'b0, 32'h44 + MEM_OFS});
    apply_reset();
    for (int t = 0; t < 3; t++) begin
      wait_ready(1, cyc, own_d, rd, er);
      e = exp_q.pop_front();
      check("dp_txn", {31'd0, own_d, rd}, {31'd0, e});
      if (t == 1) bus_dp.d_req = 0;
      @(posedge clk); #1;
      check("dp_pulse", {62'd0, bus_dp.i_ready, bus_dp.d_ready}, 64'd0);
    end
    idle_inputs();

    // Store: attributes stable on the memory side, d_rdata forced to zero.
    @(posedge clk); #1;
    bus_rr.d_req = 1; bus_rr.d_we = 1; bus_rr.d_be = 4'h3;
    bus_rr.d_addr = 32'h2000; bus_rr.d_wdata = 32'h0000ABCD;
    busy = 0;
    cyc = -1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      if (bus_rr.m_en) begin
        busy++;
        check("st_m_we", {63'd0, bus_rr.m_we}, 64'd1);
        check("st_m_be", {60'd0, bus_rr.m_be}, 64'h3);
        check("st_m_wdata", {32'd0, bus_rr.m_wdata}, 64'hABCD);
        check("st_m_addr", {32'd0, bus_rr.m_addr}, 64'h2000);
      end
      if (bus_rr.d_ready) begin
        cyc = n;
        check("st_rdata", {32'd0, bus_rr.d_rdata}, 64'd0);
        check("st_err", {63'd0, bus_rr.d_err}, 64'd0);
        break;
      end
    end
    check("st_done", {63'd0, cyc >= 0}, 64'd1);
    check("st_busy_cycles", 64'(busy), 64'd2);
    bus_rr.d_req = 0; bus_rr.d_we = 0;

    // Watchdog: no ack, m_en for exactly TIMEOUT cycles, then error response.
    rr_delay = 1000;
    @(posedge clk); #1;
    bus_rr.d_req = 1; bus_rr.d_be = 4'hF; bus_rr.d_addr = 32'h300;
    busy = 0;
    cyc = -1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (bus_rr.m_en) busy++;
      if (bus_rr.d_ready) begin
        cyc = n;
        check("to_err", {63'd0, bus_rr.d_err}, 64'd1);
        check("to_rdata", {32'd0, bus_rr.d_rdata}, 64'd0);
        break;
      end
    end
    check("to_done", {63'd0, cyc >= 0}, 64'd1);
    check("to_busy_cycles", 64'(busy), 64'd8);
    bus_rr.d_req = 0;

    // Next request after a timeout completes normally.
    rr_delay = 1;
    @(posedge clk); #1;
    bus_rr.i_req = 1; bus_rr.i_addr = 32'h104;
    wait_ready(0, cyc, own_d, rd, er);
    check("post_to_data", {31'd0, own_d, rd}, {31'd0, 1'b0, 32'h104 + MEM_OFS});
    check("post_to_err", {63'd0, er}, 64'd0);
    bus_rr.i_req = 0;

    // Ack in the very cycle the watchdog expires: normal completion.
    rr_delay = 7;
    @(posedge clk); #1;
    bus_rr.d_req = 1; bus_rr.d_addr = 32'h308;
    busy = 0;
    cyc = -1;
    for (int n = 0; n < 30; n++) begin
      @(posedge clk); #1;
      if (bus_rr.m_en) busy++;
      if (bus_rr.d_ready) begin
        cyc = n;
        check("edge_err", {63'd0, bus_rr.d_err}, 64'd0);
        check("edge_rdata", {32'd0, bus_rr.d_rdata}, {32'd0, 32'h308 + MEM_OFS});
        break;
      end
    end
    check("edge_done", {63'd0, cyc >= 0}, 64'd1);
    check("edge_busy_cycles", 64'(busy), 64'd8);
    bus_rr.d_req = 0;
    rr_delay = 1;

    // Stray m_ack while idle is ignored.
    @(posedge clk); #1;
    rr_spur = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      check("spur_state", {62'd0, dbg_rr}, 64'd0);
      check("spur_ready", {62'd0, bus_rr.i_ready, bus_rr.d_ready}, 64'd0);
    end
    rr_spur = 1'b0;

    // Reset in BUSY: m_en drops without a clock edge, request re-granted afterwards.
    rr_delay = 1000;
    @(posedge clk); #1;
    bus_rr.i_req = 1; bus_rr.i_addr = 32'h500;
    @(posedge clk); #1;
    check("rb_m_en_before", {63'd0, bus_rr.m_en}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rb_m_en_async", {63'd0, bus_rr.m_en}, 64'd0);
    check("rb_state_async", {62'd0, dbg_rr}, 64'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check("rb_no_ready", {62'd0, bus_rr.i_ready, bus_rr.d_ready}, 64'd0);
    end
    rr_delay = 1;
    @(negedge clk); rst_n = 1'b1;
    wait_ready(0, cyc, own_d, rd, er);
    check("rb_regrant", {31'd0, own_d, rd}, {31'd0, 1'b0, 32'h500 + MEM_OFS});
    check("rb_err", {63'd0, er}, 64'd0);
    bus_rr.i_req = 0;

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port of risc_v_cpu between instruction fetch (I) and load/store (D) requesters.
- Accepts one transaction at a time and drives the memory-side request/ack handshake.
- Returns read data and a one-cycle ready/err pulse to the requester it served.
- Supports round-robin or fixed D-priority arbitration, plus a watchdog timeout on memory ack.

Parameters:
AW, 32, address width
DW, 32, data width (byte enables are DW/8)
ARB_MODE, 0, 0 = round-robin, 1 = fixed D priority
TIMEOUT, 255, max BUSY cycles waiting for m_ack; 0 disables the watchdog

Ports:
CLK  in  1  system clock, rising edge
RES  in  1  asynchronous reset, active-low
i_req  in  1  fetch request, held until i_ready
i_addr  in  AW  fetch address
i_ready  out  1  one-cycle completion pulse
i_rdata  out  DW  fetched word, valid with i_ready
i_err  out  1  timeout flag, valid with i_ready
d_req  in  1  data request, held until d_ready
d_we  in  1  1 = store
d_be  in  DW/8  byte enables
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_ready  out  1  one-cycle completion pulse
d_rdata  out  DW  load data, valid with d_ready; 0 for stores
d_err  out  1  timeout flag, valid with d_ready
m_en  out  1  memory request, high throughout BUSY
m_we  out  1  memory write
m_be  out  DW/8  memory byte enables
m_addr  out  AW  memory address
m_wdata  out  DW  memory write data
m_rdata  in  DW  memory read data, valid with m_ack
m_ack  in  1  one-cycle completion from memory

Behaviour:
- Reset (RES=0, async): state=IDLE and every output reads 0, including m_en, which drops immediately. last_grant=D, timeout counter=0. Any in-flight transaction is abandoned with no ready pulse.
- FSM states: IDLE, BUSY, RESP.
- IDLE: sample i_req and d_req.
  - Neither asserted: stay in IDLE.
  - Exactly one asserted: grant it.
  - Both asserted, ARB_MODE=0: grant the side not equal to last_grant.
  - Both asserted, ARB_MODE=1: grant D.
- On grant:
  - latch owner, addr, we, be, wdata into registers; go to BUSY; clear the counter.
  - For I grants, latch we=0 and be=all ones.
- BUSY: m_* driven from the latched registers, m_en=1.
  - m_ack=1: capture m_rdata (forced to 0 if we=1), err=0, go to RESP, last_grant=owner.
  - TIMEOUT≠0 and counter==TIMEOUT-1 with no ack: err=1, rdata=0, go to RESP.
  - Otherwise counter+1.
- RESP: owner's ready=1 and err valid; m_en=0; go to IDLE next cycle.
- Latency: grant at cycle G, BUSY from G+1, ack at G+1+k gives ready at G+2+k. Minimum request-to-ready is 3 cycles.
- Requester rule: deassert req in the cycle after ready. Because RESP→IDLE inserts one cycle, the served request is never re-granted.
- Non-owner ready/rdata/err stay 0. Non-owner req may assert at any time and is held pending with no loss.
- m_ack while in IDLE or RESP is ignored. An m_ack arriving in the same cycle the watchdog expires wins: normal completion, err=0.
- I-side inputs changing while I is not the owner have no effect, since inputs are latched at grant.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, BUSY, RESP}
  - owner encoding {OWN_I=0, OWN_D=1}
  - ARB_RR / ARB_DPRIO constants
- Sub-module arb2_rr: combinational 2-way grant from req_i, req_d, last_grant and mode. It outputs grant_valid and grant_owner, and is reused by a future cache-fill arbiter.

Test Plan:
- i_req=1 alone, i_addr=0x100, memory acks 1 cycle after m_en with 0xDEADBEEF -> m_addr=0x100, m_we=0, m_be=0xF; i_ready pulses once with i_rdata=0xDEADBEEF, i_err=0; ready arrives 3 cycles after req.
- ARB_MODE=0, i_req and d_req both held high from reset for 4 transactions -> owners I, D, I, D; each ready pulse exactly one cycle.
- ARB_MODE=1, same stimulus -> D granted first, I served only when d_req is low during IDLE.
- Store d_we=1, d_be=0x3, d_addr=0x2000, d_wdata=0x0000ABCD -> m_we=1, m_be=0x3, m_wdata=0x0000ABCD held stable until m_ack; d_rdata=0.
- TIMEOUT=8, memory never acks -> m_en high for exactly 8 cycles, then d_ready=1 with d_err=1 and d_rdata=0; the next request completes normally.
- RES driven low during BUSY -> m_en=0 in the same cycle with no clock edge; no ready pulse; after release the pending i_req is granted from IDLE.
